// File: rtl/classify_scheduler_pkg.sv
// Shared types and helpers for the time-multiplexed classification layer.
// Holds the scheduler state encoding and the address-width helper.
package classify_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Address width that stays at least one bit wide for single-entry memories.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/classify_mac_sat.sv
// Shared multiply-accumulate with bias preload and shift-and-saturate output.
// The accumulator is wide enough to never overflow; only the result clamps.
module classify_mac_sat #(
  parameter int input_bitlength  = 12,
  parameter int output_bitlength = 8,
  parameter int in_dim           = 5,
  parameter int FRAC_BITS        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        acc_en,
  input  logic [input_bitlength-1:0]  h_data,
  input  logic [input_bitlength-1:0]  w_data,
  input  logic [input_bitlength-1:0]  b_data,
  output logic [output_bitlength-1:0] result
);

  localparam int prod_w = 2 * input_bitlength;
  localparam int acc_w  = prod_w + $clog2(in_dim) + 1;

  logic signed [prod_w-1:0]           prod;
  logic signed [acc_w-1:0]            prod_ext;
  logic signed [acc_w-1:0]            bias_ext;
  logic signed [acc_w-1:0]            acc;
  logic signed [acc_w-1:0]            shifted;
  logic [acc_w-output_bitlength:0]    top_bits;

  assign prod     = $signed(h_data) * $signed(w_data);
  assign prod_ext = {{(acc_w-prod_w){prod[prod_w-1]}}, prod};
  // Bias is aligned to the product's doubled fractional position.
  assign bias_ext = {{(acc_w-input_bitlength){b_data[input_bitlength-1]}}, b_data} <<< FRAC_BITS;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= bias_ext + prod_ext;
    end else if (acc_en) begin
      acc <= acc + prod_ext;
    end
  end

  assign shifted  = acc >>> FRAC_BITS;
  // The value fits the output when every bit from the output sign upward agrees.
  assign top_bits = shifted[acc_w-1:output_bitlength-1];

  always_comb begin
    result = shifted[output_bitlength-1:0];
    if (!((&top_bits) || !(|top_bits))) begin
      if (shifted[acc_w-1]) begin
        result = {1'b1, {(output_bitlength-1){1'b0}}};
      end else begin
        result = {1'b0, {(output_bitlength-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/classify_scheduler.sv
// Sequential classification layer: one shared MAC walks hidden/weight/bias
// memories, emits each saturated class score, then the argmax index.
module classify_scheduler
  import classify_scheduler_pkg::*;
#(
  parameter int input_bitlength  = 12,
  parameter int output_bitlength = 8,
  parameter int in_dim           = 5,
  parameter int out_dim          = 2,
  parameter int FRAC_BITS        = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  busy,
  output logic [addr_w(in_dim)-1:0]             h_addr,
  input  logic [input_bitlength-1:0]            h_data,
  output logic [addr_w(in_dim*out_dim)-1:0]     w_addr,
  input  logic [input_bitlength-1:0]            w_data,
  output logic [addr_w(out_dim)-1:0]            b_addr,
  input  logic [input_bitlength-1:0]            b_data,
  output logic                                  out_valid,
  output logic [addr_w(out_dim)-1:0]            out_idx,
  output logic [output_bitlength-1:0]           out_data,
  output logic                                  done,
  output logic [addr_w(out_dim)-1:0]            class_idx,
  output logic [2:0]                            dbg_state
);

  localparam int hw = addr_w(in_dim);
  localparam int ww = addr_w(in_dim * out_dim);
  localparam int bw = addr_w(out_dim);

  state_t                              state, state_nx;
  logic [hw-1:0]                       k;
  logic [bw-1:0]                       j;
  logic signed [output_bitlength-1:0]  best;
  logic [bw-1:0]                       bidx;
  logic [bw-1:0]                       class_q;
  logic [bw-1:0]                       idx_q;
  logic [output_bitlength-1:0]         data_q;
  logic [output_bitlength-1:0]         result;
  logic                                load;
  logic                                acc_en;
  logic                                last_k;
  logic                                last_j;

  assign last_k = (k == hw'(in_dim - 1));
  assign last_j = (j == bw'(out_dim - 1));

  classify_mac_sat #(
    .input_bitlength  (input_bitlength),
    .output_bitlength (output_bitlength),
    .in_dim           (in_dim),
    .FRAC_BITS        (FRAC_BITS)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .acc_en (acc_en),
    .h_data (h_data),
    .w_data (w_data),
    .b_data (b_data),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      j       <= '0;
      best    <= '0;
      bidx    <= '0;
      class_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE:  if (start) j <= '0;
        ST_BIAS:  k <= '0;
        ST_MAC:   k <= k + hw'(1);
        ST_WRITE: begin
          data_q <= result;
          idx_q  <= j;
          // Strict compare keeps the lowest index on ties.
          if (j == '0 || $signed(result) > best) begin
            best <= $signed(result);
            bidx <= j;
          end
          if (!last_j) j <= j + bw'(1);
        end
        ST_DONE:  class_q <= bidx;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    h_addr   = '0;
    w_addr   = '0;
    b_addr   = '0;
    load     = 1'b0;
    acc_en   = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_BIAS;
      ST_BIAS: begin
        b_addr   = j;
        w_addr   = ww'(int'(j));
        state_nx = ST_MAC;
      end
      ST_MAC: begin
        load   = (k == '0);
        acc_en = 1'b1;
        // Prefetch the next element so its data lands on the following cycle.
        if (!last_k) begin
          h_addr = k + hw'(1);
          w_addr = ww'((int'(k) + 1) * out_dim + int'(j));
        end else begin
          state_nx = ST_WRITE;
        end
      end
      ST_WRITE: state_nx = last_j ? ST_DONE : ST_BIAS;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_WRITE);
  assign done      = (state == ST_DONE);
  assign out_data  = out_valid ? result : data_q;
  assign out_idx   = out_valid ? j : idx_q;
  assign class_idx = done ? bidx : class_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_classify_scheduler.sv
// Bench for classify_scheduler: default-size instance plus an in_dim=1,
// out_dim=3 instance, checked against a fixed-point reference model.
module tb_classify_scheduler;
  import classify_scheduler_pkg::*;

  typedef struct packed {
    logic [4:0][11:0] h;
    logic [9:0][11:0] w;
    logic [1:0][11:0] b;
    logic [7:0]       e0;
    logic [7:0]       e1;
    logic             ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  // default instance
  logic        start_a, busy_a, out_valid_a, done_a;
  logic [2:0]  h_addr_a, dbg_a;
  logic [3:0]  w_addr_a;
  logic [0:0]  b_addr_a, out_idx_a, class_idx_a;
  logic [11:0] h_data_a, w_data_a, b_data_a;
  logic [7:0]  out_data_a;
  logic [11:0] h_mem_a[5];
  logic [11:0] w_mem_a[10];
  logic [11:0] b_mem_a[2];

  // in_dim=1, out_dim=3 instance
  logic        start_b, busy_b, out_valid_b, done_b;
  logic [0:0]  h_addr_b;
  logic [1:0]  w_addr_b, b_addr_b, out_idx_b, class_idx_b;
  logic [2:0]  dbg_b;
  logic [11:0] h_data_b, w_data_b, b_data_b;
  logic [7:0]  out_data_b;
  logic [11:0] h_mem_b[1];
  logic [11:0] w_mem_b[3];
  logic [11:0] b_mem_b[3];

  classify_scheduler dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
    .h_addr(h_addr_a), .h_data(h_data_a), .w_addr(w_addr_a), .w_data(w_data_a),
    .b_addr(b_addr_a), .b_data(b_data_a), .out_valid(out_valid_a), .out_idx(out_idx_a),
    .out_data(out_data_a), .done(done_a), .class_idx(class_idx_a), .dbg_state(dbg_a)
  );

  classify_scheduler #(.in_dim(1), .out_dim(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
    .h_addr(h_addr_b), .h_data(h_data_b), .w_addr(w_addr_b), .w_data(w_data_b),
    .b_addr(b_addr_b), .b_data(b_data_b), .out_valid(out_valid_b), .out_idx(out_idx_b),
    .out_data(out_data_b), .done(done_b), .class_idx(class_idx_b), .dbg_state(dbg_b)
  );

  // synchronous-read memories, one cycle latency
  always @(posedge clk) begin
    h_data_a <= h_mem_a[h_addr_a];
    w_data_a <= w_mem_a[w_addr_a];
    b_data_a <= b_mem_a[b_addr_a];
    h_data_b <= h_mem_b[h_addr_b];
    w_data_b <= w_mem_b[w_addr_b];
    b_data_b <= b_mem_b[b_addr_b];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: real-valued dot product in Q-format integers, floor shift, clamp.
  function automatic vec_t model(input vec_t v);
    longint acc;
    longint sc[2];
    for (int j = 0; j < 2; j++) begin
      acc = longint'($signed(v.b[j])) * 16;
      for (int i = 0; i < 5; i++)
        acc += longint'($signed(v.h[i])) * longint'($signed(v.w[i*2+j]));
      acc = acc >>> 4;
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      sc[j] = acc;
    end
    v.e0 = 8'(sc[0]);
    v.e1 = 8'(sc[1]);
    v.ec = (sc[1] > sc[0]);
    return v;
  endfunction

  function automatic logic [11:0] rnd12();
    if ($urandom_range(0, 3) == 0) return 12'($urandom_range(0, 4095));
    return 12'(int'($urandom_range(0, 128)) - 64);
  endfunction

  task automatic load_a(input vec_t v);
    for (int i = 0; i < 5; i++) h_mem_a[i] = v.h[i];
    for (int i = 0; i < 10; i++) w_mem_a[i] = v.w[i];
    for (int i = 0; i < 2; i++) b_mem_a[i] = v.b[i];
  endtask

  task automatic run_a(input vec_t v);
    int n, nv, p, jj;
    bit got_done;
    logic [7:0] e;
    load_a(v);
    exp_q.delete();
    exp_q.push_back(v.e0);
    exp_q.push_back(v.e1);
    @(negedge clk);
    start_a = 1'b1;
    n = 0; nv = 0; got_done = 0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      start_a = 1'b0;
      if (n <= 15) check("busy", busy_a, 1);
      if (n <= 14) begin
        p  = (n - 1) % 7;
        jj = (n - 1) / 7;
        if (p == 0) begin
          check("bias_b_addr", b_addr_a, jj);
          check("bias_h_addr", h_addr_a, 0);
          check("bias_w_addr", w_addr_a, jj);
        end else if (p <= 4) begin
          check("mac_h_addr", h_addr_a, p);
          check("mac_w_addr", w_addr_a, p * 2 + jj);
        end
      end
      if (out_valid_a) begin
        if (exp_q.size() == 0) check("extra_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("score", out_data_a, e);
          check("score_idx", out_idx_a, nv);
        end
        nv++;
      end
      if (done_a) begin
        got_done = 1;
        check("done_cycle", n, 15);
        check("class_idx", class_idx_a, v.ec);
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    check("valid_count", nv, 2);
    @(negedge clk);
    check("score_hold", out_data_a, v.e1);
    check("class_hold", class_idx_a, v.ec);
  endtask

  vec_t tbl[4];
  vec_t rv;
  int   nv, d1, d2, spurious;
  bit   got_done;
  logic [7:0] e;

  initial begin
    // directed table
    for (int i = 0; i < 5; i++) begin
      tbl[0].h[i] = 12'h010; tbl[0].w[i*2] = 12'h010; tbl[0].w[i*2+1] = 12'h020;
      tbl[1].h[i] = 12'h010; tbl[1].w[i*2] = 12'hF00; tbl[1].w[i*2+1] = 12'hF00;
      tbl[2].h[i] = 12'h000; tbl[2].w[i*2] = 12'h123; tbl[2].w[i*2+1] = 12'h456;
      tbl[3].h[i] = 12'h008; tbl[3].w[i*2] = 12'h010; tbl[3].w[i*2+1] = 12'hFF0;
    end
    tbl[0].b = {12'h000, 12'h010}; tbl[0].e0 = 8'h60; tbl[0].e1 = 8'h7F; tbl[0].ec = 1'b1;
    tbl[1].b = {12'h000, 12'h000}; tbl[1].e0 = 8'h80; tbl[1].e1 = 8'h80; tbl[1].ec = 1'b0;
    tbl[2].b = {12'h000, 12'hFF0}; tbl[2].e0 = 8'hF0; tbl[2].e1 = 8'h00; tbl[2].ec = 1'b1;
    tbl[3].b = {12'h020, 12'h000}; tbl[3].e0 = 8'h28; tbl[3].e1 = 8'hF8; tbl[3].ec = 1'b0;

    // clock/reset
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    load_a(tbl[0]);
    h_mem_b[0] = 12'h010;
    w_mem_b[0] = 12'h010; w_mem_b[1] = 12'h030; w_mem_b[2] = 12'h020;
    for (int i = 0; i < 3; i++) b_mem_b[i] = 12'h000;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_valid", out_valid_a, 0);
    check("rst_done", done_a, 0);
    check("rst_data", out_data_a, 0);
    check("rst_class", class_idx_a, 0);
    check("rst_state", dbg_a, ST_IDLE);
    check("rst_addrs", {h_addr_a, w_addr_a, b_addr_a}, 0);
    check("rst_b_busy", busy_b, 0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) run_a(tbl[t]);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 5; i++) rv.h[i] = rnd12();
      for (int i = 0; i < 10; i++) rv.w[i] = rnd12();
      for (int i = 0; i < 2; i++) rv.b[i] = rnd12();
      rv = model(rv);
      run_a(rv);
    end

    // start held high: mid-run starts ignored, second run right after DONE
    load_a(tbl[0]);
    @(negedge clk);
    start_a = 1'b1;
    nv = 0; d1 = -1; d2 = -1;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (n == 16) check("b2b_idle_gap", busy_a, 0);
      if (n == 17) check("b2b_restart", busy_a, 1);
      if (out_valid_a) nv++;
      if (done_a) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
        check("b2b_class", class_idx_a, 1);
      end
      if (n == 31) start_a = 1'b0;
    end
    check("b2b_done1", d1, 15);
    check("b2b_done2", d2, 31);
    check("b2b_valids", nv, 4);

    // reset in the middle of a run
    load_a(tbl[3]);
    @(negedge clk);
    start_a = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", dbg_a, ST_IDLE);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_data", out_data_a, 0);
    check("mid_rst_class", class_idx_a, 0);
    check("mid_rst_flags", {out_valid_a, done_a}, 0);
    check("mid_rst_addrs", {h_addr_a, w_addr_a, b_addr_a}, 0);
    rst = 1'b0;
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_a || done_a) spurious++;
    end
    check("mid_rst_no_output", spurious, 0);
    run_a(tbl[3]);

    // in_dim=1, out_dim=3 instance
    exp_q.delete();
    exp_q.push_back(8'h10); exp_q.push_back(8'h30); exp_q.push_back(8'h20);
    @(negedge clk);
    start_b = 1'b1;
    nv = 0; got_done = 0;
    for (int n = 1; n <= 30 && !got_done; n++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (n == 1 || n == 4 || n == 7) begin
        check("b_bias_b_addr", b_addr_b, (n - 1) / 3);
        check("b_bias_w_addr", w_addr_b, (n - 1) / 3);
        check("b_bias_h_addr", h_addr_b, 0);
      end
      if (out_valid_b) begin
        if (exp_q.size() == 0) check("b_extra_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("b_score", out_data_b, e);
          check("b_score_idx", out_idx_b, nv);
        end
        nv++;
      end
      if (done_b) begin
        got_done = 1;
        check("b_done_cycle", n, 10);
        check("b_class_idx", class_idx_b, 1);
      end
    end
    if (!got_done) check("b_done_timeout", 0, 1);
    check("b_valid_count", nv, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
